nmt_remote_mem_req: RTL and testbench
=====================================

Name: nmt_remote_mem_req

Overview:
- Initiator side of the NMT remote/shared memory access path.
- The pipeline memory stage services cmd_type 2'b00 loads and stores from its local array. This block takes the remaining accesses (cmd_type != 2'b00) and issues them as tagged requests on a valid/ready port toward the shared memory responder.
- It tracks one outstanding access, waits for the matching response, and returns ALU, IR and LMD to writeback with a one-cycle done pulse.
- The pipeline is stalled via issue_ready while an access is in flight.

Parameters:
- ADDR_W, 9: width of req_addr; taken from addr[ADDR_W-1:0].
- TAG_W, 4: width of the request/response tag.
- TIMEOUT, 255: maximum cycles in WAIT_RSP before the access is aborted.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- issue_valid  in  1  pipeline presents an access.
- issue_ready  out  1  block can accept an access (stall when low).
- instr  in  32  instruction; [6:0] is the opcode.
- addr  in  32  ALU result (effective address).
- wdata  in  32  store data (reg2).
- cmd_type  in  2  2'b00 = local (ignored here); any other value = remote.
- req_valid  out  1  request valid.
- req_ready  in  1  responder accepts the request.
- req_we  out  1  1 = store, 0 = load.
- req_addr  out  ADDR_W  request address.
- req_wdata  out  32  store data (0 for loads).
- req_tag  out  TAG_W  request tag.
- rsp_valid  in  1  response valid; always accepted, no backpressure.
- rsp_tag  in  TAG_W  response tag.
- rsp_rdata  in  32  load data.
- done_valid  out  1  one-cycle completion pulse.
- done_alu  out  32  captured addr.
- done_ir  out  32  captured instr.
- done_lmd  out  32  load data; 0 for stores and timeouts.
- timeout_err  out  1  asserted together with done_valid when the access timed out.

Behaviour:
- Reset values: state IDLE; all outputs 0 except issue_ready = 1; tag counter 0; timeout counter 0.
- Reset mid-operation drops the outstanding access with no done pulse. A response arriving after reset is ignored.
- State IDLE:
  - issue_ready = 1.
  - Accept when issue_valid && cmd_type != 2'b00 && opcode is LOAD (7'b0000011) or STORE (7'b0100011).
  - On accept, capture instr, addr, wdata (0 if load) and req_we; drive req_tag = tag counter; go to REQ.
  - Any other issue (local cmd_type, or a non-memory opcode) is consumed with no request and no done pulse.
- State REQ:
  - req_valid = 1; issue_ready = 0.
  - req_addr, req_we, req_wdata and req_tag stay stable until the handshake.
  - On req_valid && req_ready: tag counter increments, wrapping at 2^TAG_W; clear the timeout counter; go to WAIT_RSP.
  - No timeout applies in REQ.
- State WAIT_RSP:
  - req_valid = 0.
  - On rsp_valid && rsp_tag == captured tag: latch done_lmd = rsp_rdata for a load, 0 for a store; go to DONE.
  - rsp_valid with a mismatched tag is dropped with no state change.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT: done_lmd = 0, timeout_err = 1, go to DONE.
  - If a matching response arrives in the same cycle the counter reaches TIMEOUT, the response wins and timeout_err = 0.
- State DONE:
  - done_valid = 1 for exactly one cycle.
  - done_alu, done_ir, done_lmd and timeout_err are valid in that cycle and held until the next done pulse.
  - issue_ready = 0; next state is IDLE.
- Latency:
  - Accept at cycle N -> req_valid at N+1.
  - Handshake at cycle H -> earliest matching response at H+1 -> done_valid at H+2.
  - Minimum issue-to-done time is 3 cycles with zero responder latency.
- Only one access is in flight at a time. issue_ready stays low from REQ through DONE.

Test Plan:
- Remote load: cmd_type=01, instr opcode 0000011, addr=0x1_0040, req_ready=1. Responder replies next cycle with tag 0 and rdata=0x3 -> req_addr=0x040, req_we=0, done_lmd=0x3, done_alu=0x10040, done_valid pulses once at accept+3.
- Remote store: cmd_type=10, opcode 0100011, addr=0x60, wdata=0x2. req_ready held low for 4 cycles -> request fields are stable the whole time; req_wdata=0x2, req_we=1; after the response, done_lmd=0.
- Filtering: issue with cmd_type=00 load, then cmd_type=01 with opcode 0110011 -> no req_valid and no done_valid; issue_ready stays 1.
- Tag wrap and mismatch: 17 back-to-back loads -> the 17th uses tag 0. A response with the wrong tag followed by the correct tag -> completes only on the correct tag.
- Timeout: TIMEOUT=8, no response -> done_valid with timeout_err=1 and done_lmd=0 exactly 8 cycles after the handshake. A matching response in the 8th cycle -> timeout_err=0.
- Reset mid-WAIT_RSP: rst pulse, then a stale response -> no done_valid, issue_ready=1, tag counter back to 0.

Source files
------------

// File: rtl/nmt_remote_mem_req.sv
// Initiator for remote/shared memory accesses: one tagged request in flight, done pulse back to writeback.
// Accept->req_valid 1 cycle; handshake->done >= 2 cycles; issue_ready low from REQ through DONE.
module nmt_remote_mem_req #(
  parameter int ADDR_W  = 9,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [31:0]       instr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [1:0]        cmd_type,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [31:0]       req_wdata,
  output logic [TAG_W-1:0]  req_tag,
  input  logic              rsp_valid,
  input  logic [TAG_W-1:0]  rsp_tag,
  input  logic [31:0]       rsp_rdata,
  output logic              done_valid,
  output logic [31:0]       done_alu,
  output logic [31:0]       done_ir,
  output logic [31:0]       done_lmd,
  output logic              timeout_err
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int         CNT_W    = $clog2(TIMEOUT + 1);
  // The handshake cycle counts toward the budget, so the abort decision is taken
  // in the (TIMEOUT-1)th wait cycle and done lands TIMEOUT cycles after the handshake.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t           state;
  logic [TAG_W-1:0] tag_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [31:0]      cap_alu;
  logic [31:0]      cap_ir;

  logic is_mem_op;
  logic accept;
  logic is_store;
  logic rsp_hit;

  assign is_mem_op = (instr[6:0] == OP_LOAD) || (instr[6:0] == OP_STORE);
  assign is_store  = (instr[6:0] == OP_STORE);
  assign accept    = issue_valid && (cmd_type != 2'b00) && is_mem_op;
  assign rsp_hit   = rsp_valid && (rsp_tag == req_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      issue_ready <= 1'b1;
      req_valid   <= 1'b0;
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_tag     <= '0;
      done_valid  <= 1'b0;
      done_alu    <= '0;
      done_ir     <= '0;
      done_lmd    <= '0;
      timeout_err <= 1'b0;
      tag_cnt     <= '0;
      tmo_cnt     <= '0;
      cap_alu     <= '0;
      cap_ir      <= '0;
    end else begin
      done_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          // Local or non-memory issues are simply consumed while we stay ready.
          if (accept) begin
            cap_ir      <= instr;
            cap_alu     <= addr;
            req_we      <= is_store;
            req_addr    <= addr[ADDR_W-1:0];
            req_wdata   <= is_store ? wdata : 32'd0;
            req_tag     <= tag_cnt;
            req_valid   <= 1'b1;
            issue_ready <= 1'b0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            tag_cnt   <= tag_cnt + 1'b1;
            tmo_cnt   <= '0;
            state     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_hit) begin
            done_lmd    <= req_we ? 32'd0 : rsp_rdata;
            timeout_err <= 1'b0;
            done_alu    <= cap_alu;
            done_ir     <= cap_ir;
            done_valid  <= 1'b1;
            state       <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            done_lmd    <= 32'd0;
            timeout_err <= 1'b1;
            done_alu    <= cap_alu;
            done_ir     <= cap_ir;
            done_valid  <= 1'b1;
            state       <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          issue_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nmt_remote_mem_req.sv
// Directed bench: timestamp-based transaction model checked every cycle, plus literal spot checks.
module tb_nmt_remote_mem_req;
  localparam int ADDR_W = 9;
  localparam int TAG_W  = 4;
  localparam int TMO    = 8;

  localparam logic [31:0] I_LOAD  = 32'h0000_2083;
  localparam logic [31:0] I_STORE = 32'h0020_2023;
  localparam logic [31:0] I_ADD   = 32'h0020_80b3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic issue_valid = 1'b0;
  logic issue_ready;
  logic [31:0] instr = '0, addr = '0, wdata = '0;
  logic [1:0] cmd_type = '0;
  logic req_valid, req_ready = 1'b0, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic rsp_valid = 1'b0;
  logic [TAG_W-1:0] rsp_tag = '0;
  logic [31:0] rsp_rdata = '0;
  logic done_valid;
  logic [31:0] done_alu, done_ir, done_lmd;
  logic timeout_err;

  nmt_remote_mem_req #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .instr(instr), .addr(addr), .wdata(wdata), .cmd_type(cmd_type),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_rdata(rsp_rdata),
    .done_valid(done_valid), .done_alu(done_alu), .done_ir(done_ir),
    .done_lmd(done_lmd), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model: an access is a set of cycle stamps (accept, handshake, done).
  bit          started = 0;
  int          m_acc = -1, m_hs = -1, m_dn = -1;
  int          m_tagc = 0;
  logic [31:0] m_ir, m_alu, m_wd;
  logic        m_we;
  logic [3:0]  m_tag;
  logic [31:0] p_lmd;
  logic        p_err;
  logic [31:0] md_alu = '0, md_ir = '0, md_lmd = '0;
  logic        md_err = 1'b0;

  // Observations used by the literal checks.
  int          done_cnt = 0, req_cyc_cnt = 0, last_done = -1, last_hs = -1;
  logic [3:0]  last_tag;
  logic [8:0]  last_addr;
  logic        last_we;
  logic [31:0] last_wd;

  always @(negedge clk) begin
    bit in_flight, exp_rv;
    in_flight = (m_acc >= 0) && (cyc > m_acc) && (m_dn < 0 || cyc <= m_dn);
    exp_rv    = (m_acc >= 0) && (cyc > m_acc) && (m_hs < 0 || cyc <= m_hs);
    if (cyc == m_dn) begin
      md_alu = m_alu; md_ir = m_ir; md_lmd = p_lmd; md_err = p_err;
    end
    if (started) begin
      chk("issue_ready", 32'(issue_ready), 32'(!in_flight));
      chk("req_valid", 32'(req_valid), 32'(exp_rv));
      chk("done_valid", 32'(done_valid), 32'(cyc == m_dn));
      chk("done_alu", done_alu, md_alu);
      chk("done_ir", done_ir, md_ir);
      chk("done_lmd", done_lmd, md_lmd);
      chk("timeout_err", 32'(timeout_err), 32'(md_err));
      if (exp_rv) begin
        chk("req_addr", 32'(req_addr), 32'(m_alu[8:0]));
        chk("req_we", 32'(req_we), 32'(m_we));
        chk("req_wdata", req_wdata, m_wd);
        chk("req_tag", 32'(req_tag), 32'(m_tag));
      end
      if (req_valid) begin
        req_cyc_cnt++; last_tag = req_tag; last_addr = req_addr;
        last_we = req_we; last_wd = req_wdata;
        if (req_ready) last_hs = cyc;
      end
      if (done_valid) begin done_cnt++; last_done = cyc; end
    end
    if (rst) begin
      m_acc = -1; m_hs = -1; m_dn = -1; m_tagc = 0;
      md_alu = '0; md_ir = '0; md_lmd = '0; md_err = 1'b0;
      started = 1;
    end else if (!in_flight && issue_valid && cmd_type != 2'b00 &&
                 (instr[6:0] == 7'h03 || instr[6:0] == 7'h23)) begin
      m_acc = cyc; m_hs = -1; m_dn = -1;
      m_ir = instr; m_alu = addr; m_we = (instr[6:0] == 7'h23);
      m_wd = m_we ? wdata : 32'd0; m_tag = 4'(m_tagc);
    end else if (exp_rv && req_ready) begin
      m_hs = cyc; m_tagc = (m_tagc + 1) % 16;
    end else if (m_hs >= 0 && cyc > m_hs && m_dn < 0) begin
      if (rsp_valid && rsp_tag == m_tag) begin
        m_dn = cyc + 1; p_lmd = m_we ? 32'd0 : rsp_rdata; p_err = 1'b0;
      end else if (cyc - m_hs == TMO - 1) begin
        m_dn = cyc + 1; p_lmd = 32'd0; p_err = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!issue_ready && n < 50) begin tick(); n++; end
    chk("idle_wait", 32'(issue_ready), 32'd1);
  endtask

  int acc_c;

  task automatic access(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] ct, input int rdy_dly, input int rsp_dly,
                        input logic [31:0] rd, input bit bad_first);
    logic [3:0] tg;
    acc_c = cyc;
    issue_valid = 1'b1; instr = ins; addr = a; wdata = wd; cmd_type = ct;
    tick();
    issue_valid = 1'b0;
    repeat (rdy_dly) tick();
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    tg = req_tag;
    if (rsp_dly >= 0) begin
      repeat (rsp_dly) tick();
      if (bad_first) begin
        rsp_valid = 1'b1; rsp_tag = tg + 4'd1; rsp_rdata = 32'hDEAD_BEEF; tick();
      end
      rsp_valid = 1'b1; rsp_tag = tg; rsp_rdata = rd; tick();
      rsp_valid = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    int d0, r0;
    logic [3:0] tg;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Remote load, zero-latency responder
    d0 = done_cnt;
    access(I_LOAD, 32'h0001_0040, 32'h55, 2'b01, 0, 0, 32'h3, 0);
    chk("ld_done_lat", 32'(last_done - acc_c), 32'd3);
    chk("ld_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("ld_lmd", done_lmd, 32'h3);
    chk("ld_alu", done_alu, 32'h0001_0040);
    chk("ld_addr", 32'(last_addr), 32'h040);
    chk("ld_we", 32'(last_we), 32'd0);
    chk("ld_tag", 32'(last_tag), 32'd0);

    // Remote store with responder stalling the request 4 cycles
    r0 = req_cyc_cnt;
    access(I_STORE, 32'h60, 32'h2, 2'b10, 4, 1, 32'hFFFF_FFFF, 0);
    chk("st_req_cycles", 32'(req_cyc_cnt - r0), 32'd5);
    chk("st_wdata", last_wd, 32'h2);
    chk("st_we", 32'(last_we), 32'd1);
    chk("st_lmd", done_lmd, 32'd0);

    // Filtering: local load, then remote non-memory opcode
    d0 = done_cnt; r0 = req_cyc_cnt;
    issue_valid = 1'b1; instr = I_LOAD; addr = 32'h10; cmd_type = 2'b00; tick();
    instr = I_ADD; cmd_type = 2'b01; tick();
    issue_valid = 1'b0; repeat (3) tick();
    chk("flt_req", 32'(req_cyc_cnt - r0), 32'd0);
    chk("flt_done", 32'(done_cnt - d0), 32'd0);
    chk("flt_ready", 32'(issue_ready), 32'd1);

    // Reset while waiting for a response, then a stale response
    d0 = done_cnt;
    issue_valid = 1'b1; instr = I_LOAD; addr = 32'h123; cmd_type = 2'b11; tick();
    issue_valid = 1'b0; req_ready = 1'b1; tick(); req_ready = 1'b0;
    tg = req_tag; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    rsp_valid = 1'b1; rsp_tag = tg; rsp_rdata = 32'h77; tick(); rsp_valid = 1'b0;
    repeat (3) tick();
    chk("rst_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_ready", 32'(issue_ready), 32'd1);

    // 17 back-to-back loads: tags 0..15 then wrap to 0
    for (int i = 0; i < 17; i++) begin
      access(I_LOAD, 32'h200 + 32'(i), 32'h0, 2'b01, 0, 0, 32'h1000 + 32'(i), 0);
      if (i == 0)  chk("wrap_tag0", 32'(last_tag), 32'd0);
      if (i == 15) chk("wrap_tag15", 32'(last_tag), 32'd15);
      if (i == 16) chk("wrap_tag16", 32'(last_tag), 32'd0);
    end
    chk("wrap_lmd", done_lmd, 32'h1010);

    // Wrong tag first, then the right one
    access(I_LOAD, 32'h1AB, 32'h0, 2'b01, 0, 0, 32'hCAFE_0001, 1);
    chk("mm_lat", 32'(last_done - last_hs), 32'd3);
    chk("mm_lmd", done_lmd, 32'hCAFE_0001);

    // Timeout with no response
    access(I_LOAD, 32'h44, 32'h0, 2'b01, 0, -1, 32'h0, 0);
    chk("tmo_lat", 32'(last_done - last_hs), 32'd8);
    chk("tmo_err", 32'(timeout_err), 32'd1);
    chk("tmo_lmd", done_lmd, 32'd0);

    // Matching response in the last cycle before abort wins
    access(I_LOAD, 32'h45, 32'h0, 2'b01, 0, 6, 32'hABCD_0123, 0);
    chk("tmo_race_lat", 32'(last_done - last_hs), 32'd8);
    chk("tmo_race_err", 32'(timeout_err), 32'd0);
    chk("tmo_race_lmd", done_lmd, 32'hABCD_0123);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d so far)", n_pass, n_total);
    $fatal(1);
  end

endmodule
